// File: rtl/debounce_bank.sv
// Bank of independent switch debouncers: per-channel polarity, synchroniser and a
// lockout FSM with programmable settle time, plus registered rise/fall/long-press pulses.
module debounce_bank #(
  parameter int              NCH         = 4,
  parameter int              SETTLE      = 32768,
  parameter int              SYNC_STAGES = 2,
  parameter logic [NCH-1:0]  POL         = 4'b0011,
  parameter int              LONG        = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] sw_in,
  output logic [NCH-1:0] level,
  output logic [NCH-1:0] rise,
  output logic [NCH-1:0] fall,
  output logic [NCH-1:0] long,
  output logic           any_evt
);

  localparam int CNT_MAX = (SETTLE > LONG) ? SETTLE : LONG;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] SETTLE_END = CW'(SETTLE - 1);
  localparam logic [CW-1:0] LONG_END   = CW'((LONG > 0) ? LONG - 1 : 0);
  localparam logic [CW-1:0] LONG_SAT   = CW'(LONG);

  typedef enum logic [1:0] {
    STABLE_0 = 2'd0,
    WAIT_1   = 2'd1,
    STABLE_1 = 2'd2,
    WAIT_0   = 2'd3
  } state_t;

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      logic                   x_d;
      logic [SYNC_STAGES-1:0] sync_q;
      logic                   s;
      state_t                 state_q;
      logic [CW-1:0]          cnt_q;
      logic                   level_q;
      logic                   rise_q;
      logic                   fall_q;
      logic                   long_q;

      // Inversion sits ahead of the first flop so reset value 0 means "inactive".
      assign x_d = sw_in[gi] ^ POL[gi];

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          sync_q <= '0;
        end else begin
          sync_q <= {sync_q[SYNC_STAGES-2:0], x_d};
        end
      end

      assign s = sync_q[SYNC_STAGES-1];

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          state_q <= STABLE_0;
          cnt_q   <= '0;
          level_q <= 1'b0;
          rise_q  <= 1'b0;
          fall_q  <= 1'b0;
          long_q  <= 1'b0;
        end else begin
          rise_q <= 1'b0;
          fall_q <= 1'b0;
          long_q <= 1'b0;
          case (state_q)
            STABLE_0: begin
              if (s) begin
                state_q <= WAIT_1;
                cnt_q   <= '0;
                level_q <= 1'b1;
                rise_q  <= 1'b1;
              end
            end
            WAIT_1: begin
              if (cnt_q == SETTLE_END) begin
                state_q <= STABLE_1;
                cnt_q   <= '0;
              end else begin
                cnt_q <= cnt_q + CW'(1);
              end
            end
            STABLE_1: begin
              if (!s) begin
                state_q <= WAIT_0;
                cnt_q   <= '0;
                level_q <= 1'b0;
                fall_q  <= 1'b1;
              end else if ((LONG > 0) && (cnt_q < LONG_SAT)) begin
                // Saturating at LONG makes the pulse fire once per press.
                cnt_q <= cnt_q + CW'(1);
                if (cnt_q == LONG_END) begin
                  long_q <= 1'b1;
                end
              end
            end
            WAIT_0: begin
              if (cnt_q == SETTLE_END) begin
                state_q <= STABLE_0;
                cnt_q   <= '0;
              end else begin
                cnt_q <= cnt_q + CW'(1);
              end
            end
            default: begin
              state_q <= STABLE_0;
              cnt_q   <= '0;
              level_q <= 1'b0;
            end
          endcase
        end
      end

      assign level[gi] = level_q;
      assign rise[gi]  = rise_q;
      assign fall[gi]  = fall_q;
      assign long[gi]  = long_q;
    end
  endgenerate

  assign any_evt = |(rise | fall);

endmodule

// File: tb/tb_debounce_bank.sv
// Directed bench for debounce_bank (NCH=2, SETTLE=4, SYNC_STAGES=2, POL=2'b10, LONG=10);
// expected pulses are hand-derived edge numbers counted from each input change.
module tb_debounce_bank;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] sw_in = 2'b10;
  logic [1:0] level;
  logic [1:0] rise;
  logic [1:0] fall;
  logic [1:0] long;
  logic       any_evt;

  int n_checks = 0;
  int n_fail   = 0;

  debounce_bank #(
    .NCH(2),
    .SETTLE(4),
    .SYNC_STAGES(2),
    .POL(2'b10),
    .LONG(10)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sw_in(sw_in),
    .level(level),
    .rise(rise),
    .fall(fall),
    .long(long),
    .any_evt(any_evt)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance one edge and compare every output against the supplied expectation.
  task automatic step_chk(input string tag, input int n, input logic [1:0] el,
                          input logic [1:0] er, input logic [1:0] ef, input logic [1:0] eg);
    tick();
    check_val($sformatf("%s_level_e%0d", tag, n), 32'(level), 32'(el));
    check_val($sformatf("%s_rise_e%0d", tag, n), 32'(rise), 32'(er));
    check_val($sformatf("%s_fall_e%0d", tag, n), 32'(fall), 32'(ef));
    check_val($sformatf("%s_long_e%0d", tag, n), 32'(long), 32'(eg));
    check_val($sformatf("%s_anyevt_e%0d", tag, n), 32'(any_evt), 32'(|(er | ef)));
  endtask

  // Input for channels in m became active just before edge 1 and is held.
  task automatic press_hold(input string tag, input logic [1:0] m, input int nedges);
    for (int n = 1; n <= nedges; n++) begin
      step_chk(tag, n, (n >= 3) ? m : 2'b00, (n == 3) ? m : 2'b00, 2'b00,
               (n == 17) ? m : 2'b00);
    end
    $display("phase %s: %0d edges checked", tag, nedges);
  endtask

  // Input for channels in m went inactive just before edge 1; they are in or entering STABLE_1.
  task automatic release_chk(input string tag, input logic [1:0] m);
    for (int n = 1; n <= 10; n++) begin
      step_chk(tag, n, (n < 3) ? m : 2'b00, 2'b00, (n == 3) ? m : 2'b00, 2'b00);
    end
    $display("phase %s: release checked", tag);
  endtask

  initial begin
    // Reset held: everything zero.
    repeat (2) tick();
    check_val("rst_level", 32'(level), 0);
    check_val("rst_rise", 32'(rise), 0);
    check_val("rst_fall", 32'(fall), 0);
    check_val("rst_long", 32'(long), 0);
    check_val("rst_anyevt", 32'(any_evt), 0);
    rst = 1'b1;
    for (int n = 1; n <= 4; n++) step_chk("idle", n, 2'b00, 2'b00, 2'b00, 2'b00);
    $display("phase reset: idle checked");

    // Clean press, long press once while held, then release.
    sw_in = 2'b11;
    press_hold("press1", 2'b01, 30);
    sw_in = 2'b10;
    release_chk("rel1", 2'b01);

    // Second press re-arms long detection.
    sw_in = 2'b11;
    press_hold("press2", 2'b01, 20);
    sw_in = 2'b10;
    release_chk("rel2", 2'b01);

    // Bounce: input toggles around the press, one rise only.
    for (int n = 1; n <= 20; n++) begin
      sw_in[0] = (n == 2 || n == 4) ? 1'b0 : 1'b1;
      step_chk("bounce", n, (n >= 3) ? 2'b01 : 2'b00, (n == 3) ? 2'b01 : 2'b00, 2'b00,
               (n == 17) ? 2'b01 : 2'b00);
    end
    $display("phase bounce: 20 edges checked");
    sw_in[0] = 1'b0;
    release_chk("rel_bounce", 2'b01);

    // Glitch: one-cycle pulse gives 5 cycles of level; re-press from edge 8 is locked out
    // until STABLE_0 returns at edge 12, so the second rise lands on edge 13.
    for (int n = 1; n <= 16; n++) begin
      sw_in[0] = (n == 1 || n >= 8) ? 1'b1 : 1'b0;
      step_chk("glitch", n, ((n >= 3 && n <= 7) || n >= 13) ? 2'b01 : 2'b00,
               (n == 3 || n == 13) ? 2'b01 : 2'b00, (n == 8) ? 2'b01 : 2'b00, 2'b00);
    end
    $display("phase glitch: 16 edges checked");
    sw_in[0] = 1'b0;
    release_chk("rel_glitch", 2'b01);

    // Polarity: channel 1 is active-low.
    sw_in = 2'b00;
    press_hold("pol", 2'b10, 8);
    sw_in = 2'b10;
    release_chk("rel_pol", 2'b10);

    // Both channels pressed together.
    sw_in = 2'b01;
    press_hold("both", 2'b11, 8);
    sw_in = 2'b10;
    release_chk("rel_both", 2'b11);

    // Async reset mid-WAIT_1, between clock edges.
    sw_in = 2'b11;
    press_hold("rst_pre", 2'b01, 3);
    #2;
    rst = 1'b0;
    #1;
    check_val("arst_level", 32'(level), 0);
    check_val("arst_rise", 32'(rise), 0);
    check_val("arst_fall", 32'(fall), 0);
    check_val("arst_long", 32'(long), 0);
    check_val("arst_anyevt", 32'(any_evt), 0);
    tick();
    check_val("arst_hold_level", 32'(level), 0);
    check_val("arst_hold_rise", 32'(rise), 0);
    rst = 1'b1;
    press_hold("rst_post", 2'b01, 20);
    sw_in = 2'b10;
    release_chk("rel_rst", 2'b01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
